// File: rtl/hynoc_local_mux_interface.sv
// Purpose: shares one HyNoC router local port among NUM_CHANNELS clients (ingress RR mux, egress demux).
// Latency: ingress flit reaches the router 2 cycles after a client write into an idle mux; egress flit visible 1 cycle after router write.
// Backpressure: port_ingress_full stalls the granted channel; egress has none, overflow or a bad channel id drops and sets egress_drop_err.
// Optional: define HYNOC_LOCAL_MUX_STATS_EN to build the per-channel forwarded-packet counters.

// Show-ahead FIFO; full/empty are derived from the level output by the user.
module hynoc_local_mux_fifo #(
    parameter int W             = 33,
    parameter int LD            = 3,
    parameter bit WR_ON_FULL_RD = 1'b0
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          wr,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd,
    output logic [W-1:0]  head,
    output logic [LD:0]   level
);
    localparam int DEPTH = 1 << LD;

    logic [W-1:0]  mem [DEPTH];
    logic [LD-1:0] wr_ptr;
    logic [LD-1:0] rd_ptr;
    logic [LD:0]   count;
    logic          empty;
    logic          full;
    logic          rd_ok;
    logic          wr_ok;

    assign empty = (count == '0);
    assign full  = count[LD];
    assign rd_ok = rd && !empty;
    // When enabled, a pop in the same cycle frees the slot so a write on full is kept.
    assign wr_ok = wr && (!full || (WR_ON_FULL_RD && rd_ok));
    assign head  = mem[rd_ptr];
    assign level = count;

    // Storage array, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_dat;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + LD'(1);
            if (rd_ok) rd_ptr <= rd_ptr + LD'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (LD+1)'(1);
                2'b01:   count <= count - (LD+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module hynoc_local_mux_interface #(
    parameter int NUM_CHANNELS    = 4,
    parameter int LOG2_FIFO_DEPTH = 3,
    parameter int FLIT_WIDTH      = 33,
    parameter int CHAN_LSB        = 0
) (
    input  logic                               local_clk,
    input  logic                               local_arst_n,
    output logic                               port_ingress_write,
    output logic [FLIT_WIDTH-1:0]              port_ingress_data,
    input  logic                               port_ingress_full,
    input  logic                               port_egress_write,
    input  logic [FLIT_WIDTH-1:0]              port_egress_data,
    output logic [LOG2_FIFO_DEPTH:0]           port_egress_fifo_level,
    input  logic [NUM_CHANNELS-1:0]            local_ingress_write,
    input  logic [NUM_CHANNELS*FLIT_WIDTH-1:0] local_ingress_data,
    output logic [NUM_CHANNELS-1:0]            local_ingress_full,
    input  logic [NUM_CHANNELS-1:0]            local_egress_read,
    output logic [NUM_CHANNELS*FLIT_WIDTH-1:0] local_egress_data,
    output logic [NUM_CHANNELS-1:0]            local_egress_empty,
    output logic                               egress_drop_err,
    output logic [NUM_CHANNELS*16-1:0]         stat_ingress_pkt_count
);
    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int LW = LOG2_FIFO_DEPTH + 1;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    typedef enum logic [1:0] {EG_HEADER, EG_BODY, EG_DROP} eg_state_t;

    logic [FLIT_WIDTH-1:0] ing_head  [NUM_CHANNELS];
    logic [LW-1:0]         ing_level [NUM_CHANNELS];
    logic [LW-1:0]         eg_level  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ing_empty;
    logic [NUM_CHANNELS-1:0] ing_pop;
    logic [NUM_CHANNELS-1:0] eg_wr;
    logic [NUM_CHANNELS-1:0] eg_full;

    arb_state_t    arb_state;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] grant;
    logic [CW-1:0] scan_idx;
    logic          scan_found;
    logic [CW-1:0] next_ptr;
    logic          pop_last;

    eg_state_t     eg_state;
    logic [CW-1:0] eg_target;
    logic [3:0]    hdr_chan;
    logic          chan_ok;
    logic          eg_last;
    logic          hdr_bad;
    logic          eg_overflow;
    logic [LW-1:0] lvl_max;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        hynoc_local_mux_fifo #(
            .W(FLIT_WIDTH), .LD(LOG2_FIFO_DEPTH), .WR_ON_FULL_RD(1'b0)
        ) u_ing_fifo (
            .clk    (local_clk),
            .arst_n (local_arst_n),
            .wr     (local_ingress_write[g]),
            .wr_dat (local_ingress_data[g*FLIT_WIDTH +: FLIT_WIDTH]),
            .rd     (ing_pop[g]),
            .head   (ing_head[g]),
            .level  (ing_level[g])
        );

        hynoc_local_mux_fifo #(
            .W(FLIT_WIDTH), .LD(LOG2_FIFO_DEPTH), .WR_ON_FULL_RD(1'b1)
        ) u_eg_fifo (
            .clk    (local_clk),
            .arst_n (local_arst_n),
            .wr     (eg_wr[g]),
            .wr_dat (port_egress_data),
            .rd     (local_egress_read[g]),
            .head   (local_egress_data[g*FLIT_WIDTH +: FLIT_WIDTH]),
            .level  (eg_level[g])
        );

        assign ing_empty[g]          = (ing_level[g] == '0);
        assign local_ingress_full[g] = ing_level[g][LW-1];
        assign local_egress_empty[g] = (eg_level[g] == '0);
        assign eg_full[g]            = eg_level[g][LW-1];
        assign ing_pop[g]            = port_ingress_write && (grant == CW'(g));
    end

    // ---------------- ingress arbiter ----------------

    // Round-robin scan from rr_ptr; descending loop so the nearest channel wins.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (!ing_empty[(int'(rr_ptr) + k) % NUM_CHANNELS]) begin
                scan_found = 1'b1;
                scan_idx   = CW'((int'(rr_ptr) + k) % NUM_CHANNELS);
            end
        end
    end

    assign port_ingress_write = (arb_state == ARB_BUSY) && !ing_empty[grant] && !port_ingress_full;
    assign port_ingress_data  = ing_head[grant];
    assign pop_last           = port_ingress_write && port_ingress_data[FLIT_WIDTH-1];
    assign next_ptr           = (grant == CW'(NUM_CHANNELS - 1)) ? '0 : grant + CW'(1);

    // Packet-atomic grant: held from first flit until the last flit is popped.
    always_ff @(posedge local_clk or negedge local_arst_n) begin
        if (!local_arst_n) begin
            arb_state <= ARB_IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
        end else begin
            case (arb_state)
                ARB_IDLE: begin
                    if (scan_found) begin
                        grant     <= scan_idx;
                        arb_state <= ARB_BUSY;
                    end
                end
                default: begin
                    if (pop_last) begin
                        rr_ptr    <= next_ptr;
                        arb_state <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- egress demux ----------------

    assign hdr_chan = port_egress_data[CHAN_LSB +: 4];
    assign chan_ok  = int'(hdr_chan) < NUM_CHANNELS;
    assign eg_last  = port_egress_data[FLIT_WIDTH-1];
    assign hdr_bad  = port_egress_write && (eg_state == EG_HEADER) && !chan_ok;
    // A full FIFO being read this cycle still accepts the write.
    assign eg_overflow = |(eg_wr & eg_full & ~local_egress_read);

    // Route each router flit to the header-selected or latched target FIFO.
    always_comb begin
        eg_wr = '0;
        for (int g = 0; g < NUM_CHANNELS; g++) begin
            case (eg_state)
                EG_HEADER: eg_wr[g] = port_egress_write && chan_ok && (int'(hdr_chan) == g);
                EG_BODY:   eg_wr[g] = port_egress_write && (eg_target == CW'(g));
                default:   eg_wr[g] = 1'b0;
            endcase
        end
    end

    // Packet tracking follows the last flag regardless of drops.
    always_ff @(posedge local_clk or negedge local_arst_n) begin
        if (!local_arst_n) begin
            eg_state  <= EG_HEADER;
            eg_target <= '0;
        end else if (port_egress_write) begin
            case (eg_state)
                EG_HEADER: begin
                    if (chan_ok) begin
                        eg_target <= CW'(hdr_chan);
                        if (!eg_last) eg_state <= EG_BODY;
                    end else if (!eg_last) begin
                        eg_state <= EG_DROP;
                    end
                end
                default: begin
                    if (eg_last) eg_state <= EG_HEADER;
                end
            endcase
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge local_clk or negedge local_arst_n) begin
        if (!local_arst_n)                egress_drop_err <= 1'b0;
        else if (hdr_bad || eg_overflow)  egress_drop_err <= 1'b1;
    end

    // Deepest egress FIFO occupancy.
    always_comb begin
        lvl_max = '0;
        for (int g = 0; g < NUM_CHANNELS; g++) begin
            if (eg_level[g] > lvl_max) lvl_max = eg_level[g];
        end
    end

    // Registered copy of the deepest level, one cycle behind the FIFOs.
    always_ff @(posedge local_clk or negedge local_arst_n) begin
        if (!local_arst_n) port_egress_fifo_level <= '0;
        else               port_egress_fifo_level <= lvl_max;
    end

    // ---------------- statistics ----------------
`ifdef HYNOC_LOCAL_MUX_STATS_EN
    logic [15:0] pkt_cnt [NUM_CHANNELS];

    // Count packets whose last flit left for the router; wraps at 16 bits.
    always_ff @(posedge local_clk or negedge local_arst_n) begin
        if (!local_arst_n) begin
            for (int g = 0; g < NUM_CHANNELS; g++) pkt_cnt[g] <= '0;
        end else if (pop_last) begin
            for (int g = 0; g < NUM_CHANNELS; g++) begin
                if (grant == CW'(g)) pkt_cnt[g] <= pkt_cnt[g] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_stat
        assign stat_ingress_pkt_count[g*16 +: 16] = pkt_cnt[g];
    end
`else
    assign stat_ingress_pkt_count = '0;
`endif
endmodule

// File: tb/tb_hynoc_local_mux_interface.sv
module tb_hynoc_local_mux_interface;
    localparam int N  = 4;
    localparam int L  = 3;
    localparam int FW = 33;

    logic            local_clk = 1'b0;
    logic            local_arst_n = 1'b0;
    logic            port_ingress_write;
    logic [FW-1:0]   port_ingress_data;
    logic            port_ingress_full = 1'b0;
    logic            port_egress_write = 1'b0;
    logic [FW-1:0]   port_egress_data = '0;
    logic [L:0]      port_egress_fifo_level;
    logic [N-1:0]    local_ingress_write = '0;
    logic [N*FW-1:0] local_ingress_data = '0;
    logic [N-1:0]    local_ingress_full;
    logic [N-1:0]    local_egress_read = '0;
    logic [N*FW-1:0] local_egress_data;
    logic [N-1:0]    local_egress_empty;
    logic            egress_drop_err;
    logic [N*16-1:0] stat_ingress_pkt_count;

    hynoc_local_mux_interface #(
        .NUM_CHANNELS(N), .LOG2_FIFO_DEPTH(L), .FLIT_WIDTH(FW), .CHAN_LSB(0)
    ) dut (
        .local_clk              (local_clk),
        .local_arst_n           (local_arst_n),
        .port_ingress_write     (port_ingress_write),
        .port_ingress_data      (port_ingress_data),
        .port_ingress_full      (port_ingress_full),
        .port_egress_write      (port_egress_write),
        .port_egress_data       (port_egress_data),
        .port_egress_fifo_level (port_egress_fifo_level),
        .local_ingress_write    (local_ingress_write),
        .local_ingress_data     (local_ingress_data),
        .local_ingress_full     (local_ingress_full),
        .local_egress_read      (local_egress_read),
        .local_egress_data      (local_egress_data),
        .local_egress_empty     (local_egress_empty),
        .egress_drop_err        (egress_drop_err),
        .stat_ingress_pkt_count (stat_ingress_pkt_count)
    );

    always #5 local_clk = ~local_clk;

    typedef struct {
        logic [FW-1:0] dat;
        int            dest;       // -1: flit must be discarded
        logic [N-1:0]  exp_empty;
        logic          exp_err;
    } eg_vec_t;

    eg_vec_t       vec [7];
    logic [FW-1:0] ing_q [$];
    logic [FW-1:0] eg_q [N][$];
    int checks = 0;
    int failures = 0;
    int seen = 0;
    int run_len = 0;
    int max_run = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    // Router-side monitor: every accepted flit must match the scoreboard head.
    always @(negedge local_clk) begin
        if (local_arst_n) begin
            if (port_ingress_write) begin
                seen++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (ing_q.size() == 0) chk("ing_unexpected_flit", port_ingress_data, '0);
                else                   chk("ing_data", port_ingress_data, ing_q.pop_front());
            end else begin
                run_len = 0;
            end
        end
    end

    task automatic ing_write(input int ch, input logic [FW-1:0] d, input bit expect_fwd);
        local_ingress_write[ch] = 1'b1;
        local_ingress_data[ch*FW +: FW] = d;
        if (expect_fwd) ing_q.push_back(d);
        tick();
        local_ingress_write = '0;
    endtask

    task automatic wait_ing_drain(input int budget);
        int n = 0;
        while (ing_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("ing_drain_timeout", 64'(ing_q.size()), 0);
        repeat (3) tick();
    endtask

    task automatic eg_send(input logic [FW-1:0] d, input int dest);
        port_egress_write = 1'b1;
        port_egress_data  = d;
        if (dest >= 0) eg_q[dest].push_back(d);
        tick();
        port_egress_write = 1'b0;
    endtask

    task automatic eg_read(input int ch);
        logic [FW-1:0] exp;
        exp = (eg_q[ch].size() != 0) ? eg_q[ch].pop_front() : '0;
        chk($sformatf("eg_nonempty_ch%0d", ch), local_egress_empty[ch], 1'b0);
        chk($sformatf("eg_data_ch%0d", ch), local_egress_data[ch*FW +: FW], exp);
        local_egress_read[ch] = 1'b1;
        tick();
        local_egress_read = '0;
    endtask

    task automatic do_reset();
        local_arst_n = 1'b0;
        local_ingress_write = '0;
        local_egress_read = '0;
        port_egress_write = 1'b0;
        ing_q.delete();
        for (int c = 0; c < N; c++) eg_q[c].delete();
        repeat (3) tick();
        chk("rst_ing_write", port_ingress_write, 0);
        chk("rst_level", port_egress_fifo_level, 0);
        chk("rst_drop_err", egress_drop_err, 0);
        chk("rst_ing_full", local_ingress_full, 0);
        chk("rst_eg_empty", local_egress_empty, 4'hF);
        chk("rst_stats", stat_ingress_pkt_count, 0);
        local_arst_n = 1'b1;
        tick();
    endtask

    task automatic chk_stat(input int ch, input int exp);
`ifdef HYNOC_LOCAL_MUX_STATS_EN
        chk($sformatf("stat_ch%0d", ch), stat_ingress_pkt_count[ch*16 +: 16], 16'(exp));
`else
        chk($sformatf("stat_ch%0d_tied", ch), stat_ingress_pkt_count[ch*16 +: 16], 16'(exp * 0));
`endif
    endtask

    initial begin
        int base;
        int n;
        // Egress vectors: header ch2 + 2 body flits, bad header ch9 packet, then 1-flit to ch0.
        vec[0] = '{{1'b0, 32'h0000_A002},  2, 4'b1011, 1'b0};
        vec[1] = '{{1'b0, 32'h0000_B005},  2, 4'b1011, 1'b0};
        vec[2] = '{{1'b1, 32'h0000_C00F},  2, 4'b1011, 1'b0};
        vec[3] = '{{1'b0, 32'h0000_D009}, -1, 4'b1011, 1'b1};
        vec[4] = '{{1'b0, 32'h0000_E000}, -1, 4'b1011, 1'b1};
        vec[5] = '{{1'b1, 32'h0000_F001}, -1, 4'b1011, 1'b1};
        vec[6] = '{{1'b1, 32'h0000_1230},  0, 4'b1010, 1'b1};

        do_reset();

        // 3-flit packet from ch0 goes out as 3 back-to-back writes.
        max_run = 0;
        ing_write(0, {1'b0, 32'h0A00_0001}, 1);
        ing_write(0, {1'b0, 32'h0A00_0002}, 1);
        ing_write(0, {1'b1, 32'h0A00_0003}, 1);
        wait_ing_drain(40);
        chk("ch0_back_to_back", 64'(max_run), 3);
        chk_stat(0, 1);

        // ch1 and ch2 load simultaneously; rr pointer is now 1 so ch1 goes first, unsplit.
        local_ingress_write = 4'b0110;
        local_ingress_data[1*FW +: FW] = {1'b0, 32'h1100_0001};
        local_ingress_data[2*FW +: FW] = {1'b0, 32'h2200_0001};
        tick();
        local_ingress_data[1*FW +: FW] = {1'b1, 32'h1100_0002};
        local_ingress_data[2*FW +: FW] = {1'b1, 32'h2200_0002};
        tick();
        local_ingress_write = '0;
        ing_q.push_back({1'b0, 32'h1100_0001});
        ing_q.push_back({1'b1, 32'h1100_0002});
        ing_q.push_back({1'b0, 32'h2200_0001});
        ing_q.push_back({1'b1, 32'h2200_0002});
        wait_ing_drain(40);
        chk_stat(1, 1);
        chk_stat(2, 1);

        // Router full for 5 cycles in the middle of a ch3 packet.
        base = seen;
        for (int i = 0; i < 4; i++) ing_write(3, {(i == 3), 32'h3300_0000 + 32'(i)}, 1);
        n = 0;
        while (seen < base + 2 && n < 40) begin
            tick();
            n++;
        end
        chk("ch3_started", 64'(seen >= base + 2), 1);
        port_ingress_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge local_clk);
            chk("stall_no_write", port_ingress_write, 0);
            @(posedge local_clk);
            #1;
        end
        port_ingress_full = 1'b0;
        wait_ing_drain(40);
        chk("ch3_flit_total", 64'(seen - base), 4);
        chk_stat(3, 1);

        // Fill ch0 ingress FIFO while the router is full; the 9th write is ignored.
        port_ingress_full = 1'b1;
        for (int i = 0; i < 8; i++) ing_write(0, {(i == 7), 32'h0B00_0000 + 32'(i)}, 1);
        chk("ing_full_mask", local_ingress_full, 4'b0001);
        ing_write(0, {1'b1, 32'hDEAD_BEEF}, 0);
        chk("ing_full_held", local_ingress_full, 4'b0001);
        port_ingress_full = 1'b0;
        base = seen;
        wait_ing_drain(60);
        repeat (4) tick();
        chk("ing_full_flits_out", 64'(seen - base), 8);
        chk_stat(0, 2);

        // Egress table.
        for (int i = 0; i < 7; i++) begin
            eg_send(vec[i].dat, vec[i].dest);
            chk($sformatf("eg_vec%0d_empty", i), local_egress_empty, vec[i].exp_empty);
            chk($sformatf("eg_vec%0d_err", i), egress_drop_err, vec[i].exp_err);
        end
        chk("eg_level_after_table", port_egress_fifo_level, 3);
        for (int i = 0; i < 3; i++) eg_read(2);
        eg_read(0);
        chk("eg_all_empty", local_egress_empty, 4'hF);

        // Reset in the middle of partial ingress and egress packets.
        port_ingress_full = 1'b1;
        ing_write(1, {1'b0, 32'h5100_0001}, 0);
        ing_write(1, {1'b0, 32'h5100_0002}, 0);
        eg_send({1'b0, 32'h0000_6003}, -1);
        do_reset();
        port_ingress_full = 1'b0;
        base = seen;
        repeat (6) tick();
        chk("post_rst_no_ingress", 64'(seen - base), 0);
        eg_send({1'b1, 32'h0000_7001}, 1);
        chk("post_rst_eg_header", local_egress_empty, 4'b1101);
        eg_read(1);

        // Fill ch3 egress to depth, then read+write on full, then overflow.
        for (int i = 0; i < 8; i++) eg_send({1'b1, 32'h0000_8003 + 32'(i << 8)}, 3);
        chk("eg_level_lag", port_egress_fifo_level, 7);
        tick();
        chk("eg_level_full", port_egress_fifo_level, 8);
        chk("eg_full_no_err", egress_drop_err, 0);
        chk("eg_full_head", local_egress_data[3*FW +: FW], eg_q[3][0]);
        local_egress_read[3] = 1'b1;
        void'(eg_q[3].pop_front());
        eg_send({1'b1, 32'h0000_9903}, 3);
        local_egress_read = '0;
        chk("eg_rdwr_full_no_err", egress_drop_err, 0);
        eg_send({1'b1, 32'h0000_AA03}, -1);
        chk("eg_overflow_err", egress_drop_err, 1);
        tick();
        chk("eg_level_overflow", port_egress_fifo_level, 8);
        for (int i = 0; i < 8; i++) eg_read(3);
        chk("eg_ch3_drained", local_egress_empty, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
